// File: rtl/ddr_pkg.sv
// Shared DDR controller types: CAS request encoding and data-phase FSM states.
// No logic, no latency.
// No flow control; types only.
package ddr_pkg;

    localparam logic [2:0] RD_R  = 3'd1;
    localparam logic [2:0] RDA_R = 3'd2;
    localparam logic [2:0] WR_R  = 3'd3;
    localparam logic [2:0] WRA_R = 3'd4;

    typedef enum logic [1:0] {
        DATA_IDLE,
        DATA_WAIT,
        DATA_READ,
        DATA_WRITE
    } data_fsm_type;

    function automatic logic cas_is_legal(input logic [2:0] req);
        return (req == RD_R) || (req == RDA_R) || (req == WR_R) || (req == WRA_R);
    endfunction

    function automatic logic cas_is_wr(input logic [2:0] req);
        return (req == WR_R) || (req == WRA_R);
    endfunction

endpackage

// File: rtl/ctrl_data_fifo.sv
// Show-ahead queue of outstanding CAS entries {is_wr, start}.
// Push visible at head the cycle after; pop takes effect at the clock edge.
// Push while full and pop while empty are ignored.
module ctrl_data_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_burst_data.sv
// Data-phase engine: queues issued CAS commands and runs each DQ burst at now+latency.
// Burst starts exactly AL+CL / AL+CWL clocks after the CAS; rd_data is one register stage behind dq_in.
// No backpressure: CAS while full or illegal is dropped and flagged in err_ovf.
module ctrl_burst_data import ddr_pkg::*; #(
    parameter int DQ_W  = 8,
    parameter int DEPTH = 4,
    parameter int TS_W  = 8
) (
    input  logic              CK_t,
    input  logic              reset,
    input  logic              cas_rdy,
    input  logic [2:0]        cas_req,
    input  logic [4:0]        CL,
    input  logic [4:0]        CWL,
    input  logic [4:0]        AL,
    input  logic [4:0]        BL,
    input  logic [2*DQ_W-1:0] wr_data,
    output logic              wr_data_req,
    output logic [2*DQ_W-1:0] dq_out,
    output logic              dq_oe,
    input  logic [2*DQ_W-1:0] dq_in,
    output logic [2*DQ_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rw_done,
    output logic              q_full,
    output logic              err_ovf,
    output logic              err_coll
);
    data_fsm_type    state_q, state_d;
    logic [4:0]      beat_q, beat_d;
    logic [4:0]      half;
    logic [TS_W-1:0] now_q, now_nxt;
    logic [TS_W-1:0] lat, push_start, head_start;
    logic [TS_W:0]   head_dat;
    logic            head_wr;
    logic            fifo_full, fifo_empty;
    logic            push, pop, launch;
    logic            in_burst, last_beat, start_nxt, coll_hit;

    assign now_nxt    = now_q + TS_W'(1);
    assign half       = BL >> 1;
    assign lat        = cas_is_wr(cas_req) ? (TS_W'(AL) + TS_W'(CWL)) : (TS_W'(AL) + TS_W'(CL));
    assign push_start = now_q + lat;
    assign push       = cas_rdy && cas_is_legal(cas_req) && !fifo_full;

    ctrl_data_fifo #(.DEPTH(DEPTH), .W(TS_W + 1)) u_fifo (
        .clk      (CK_t),
        .reset    (reset),
        .push     (push),
        .push_dat ({cas_is_wr(cas_req), push_start}),
        .pop      (pop),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign head_wr    = head_dat[TS_W];
    assign head_start = head_dat[TS_W-1:0];

    // Starts are looked up one clock ahead so the burst state register is live on beat 0.
    assign in_burst  = (state_q == DATA_READ) || (state_q == DATA_WRITE);
    assign last_beat = in_burst && (beat_q == half - 5'd1);
    assign start_nxt = !fifo_empty && (head_start == now_nxt);
    assign coll_hit  = in_burst && !fifo_empty &&
                       ((head_start == now_q) || (start_nxt && !last_beat));
    assign launch    = start_nxt && (!in_burst || last_beat);
    assign pop       = launch || coll_hit;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        if (launch) begin
            state_d = head_wr ? DATA_WRITE : DATA_READ;
            beat_d  = '0;
        end else if (!in_burst || last_beat) begin
            state_d = fifo_empty ? DATA_IDLE : DATA_WAIT;
            beat_d  = '0;
        end else begin
            beat_d  = beat_q + 5'd1;
        end
    end

    always_ff @(posedge CK_t) begin
        if (reset) begin
            state_q  <= DATA_IDLE;
            beat_q   <= '0;
            now_q    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rw_done  <= 1'b0;
            err_ovf  <= 1'b0;
            err_coll <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            now_q    <= now_nxt;
            rd_valid <= (state_q == DATA_READ);
            rw_done  <= last_beat;
            if (state_q == DATA_READ) rd_data <= dq_in;
            if (cas_rdy && (fifo_full || !cas_is_legal(cas_req))) err_ovf <= 1'b1;
            if (coll_hit) err_coll <= 1'b1;
        end
    end

    // Write data arrives one clock after the request, so the request tracks the next state.
    assign wr_data_req = !reset && (state_d == DATA_WRITE);
    assign dq_oe       = (state_q == DATA_WRITE);
    assign dq_out      = dq_oe ? wr_data : '0;
    assign q_full      = fifo_full;

endmodule

// File: tb/tb_ctrl_burst_data.sv
// Bench for ctrl_burst_data: per-cycle scoreboard against a window-based burst model,
// single-command table, hand-written multi-cycle corner cases and a randomized run.
module tb_ctrl_burst_data;
    import ddr_pkg::*;

    localparam int DQ_W  = 8;
    localparam int DEPTH = 4;
    localparam int TS_W  = 8;
    localparam int W     = 2 * DQ_W;
    localparam int NC    = 512;

    logic         CK_t = 1'b0;
    logic         reset = 1'b1;
    logic         cas_rdy = 1'b0;
    logic [2:0]   cas_req = 3'd0;
    logic [4:0]   CL = 5'd11, CWL = 5'd9, AL = 5'd0, BL = 5'd8;
    logic [W-1:0] wr_data = '0, dq_in = '0;
    logic         wr_data_req, dq_oe, rd_valid, rw_done, q_full, err_ovf, err_coll;
    logic [W-1:0] dq_out, rd_data;

    always #5 CK_t = ~CK_t;

    ctrl_burst_data #(.DQ_W(DQ_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .CK_t(CK_t), .reset(reset), .cas_rdy(cas_rdy), .cas_req(cas_req),
        .CL(CL), .CWL(CWL), .AL(AL), .BL(BL),
        .wr_data(wr_data), .wr_data_req(wr_data_req), .dq_out(dq_out), .dq_oe(dq_oe),
        .dq_in(dq_in), .rd_data(rd_data), .rd_valid(rd_valid), .rw_done(rw_done),
        .q_full(q_full), .err_ovf(err_ovf), .err_coll(err_coll)
    );

    int errors = 0;
    int checks = 0;

    // scenario stimulus
    logic       ev_vld [NC];
    logic [2:0] ev_req [NC];
    int         rst_cyc;

    // expected per-cycle outputs
    logic e_rdv [NC], e_done [NC], e_req [NC], e_oe [NC], e_full [NC], e_ovf [NC], e_coll [NC];
    int   e_rdsrc [NC];
    logic [W-1:0] dq_hist [NC], wr_hist [NC];

    // observations used by the directed checks
    int obs_done, obs_first_rdv, obs_first_oe, obs_first_full, obs_rdv_cnt, obs_oe_cnt;
    logic obs_coll, obs_ovf;

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, c, act, exp);
        end
    endtask

    task automatic clear_ev();
        for (int c = 0; c < NC; c++) begin
            ev_vld[c] = 1'b0;
            ev_req[c] = 3'd0;
        end
        rst_cyc = -1;
    endtask

    // Each accepted command owns the window [S, S+BL/2-1]; a command whose start falls inside
    // the window of the burst before it is dropped. Queue residency is push+1 .. S-1.
    task automatic build_model(input int lrd, input int lwr, input int h);
        int acc_t[$];
        int acc_s[$];
        bit acc_w[$];
        int cur_s;
        cur_s = -1000;
        for (int c = 0; c < NC; c++) begin
            e_rdv[c] = 0; e_done[c] = 0; e_req[c] = 0; e_oe[c] = 0;
            e_full[c] = 0; e_ovf[c] = 0; e_coll[c] = 0; e_rdsrc[c] = 0;
        end
        for (int c = 0; c < NC; c++) begin
            if (ev_vld[c]) begin
                bit legal;
                bit wr;
                int occ;
                legal = ev_req[c] inside {RD_R, RDA_R, WR_R, WRA_R};
                wr    = (ev_req[c] == WR_R) || (ev_req[c] == WRA_R);
                occ   = 0;
                foreach (acc_t[i]) if (acc_t[i] < c && c <= acc_s[i] - 1) occ++;
                if (!legal || occ == DEPTH) begin
                    for (int k = c + 1; k < NC; k++) e_ovf[k] = 1;
                end else begin
                    acc_t.push_back(c);
                    acc_s.push_back(c + (wr ? lwr : lrd));
                    acc_w.push_back(wr);
                end
            end
        end
        for (int c = 0; c < NC; c++) begin
            int occ;
            occ = 0;
            foreach (acc_t[i]) if (acc_t[i] < c && c <= acc_s[i] - 1) occ++;
            e_full[c] = (occ == DEPTH);
        end
        foreach (acc_s[i]) begin
            int s;
            s = acc_s[i];
            if (s < cur_s + h) begin
                for (int k = s; k < NC; k++) e_coll[k] = 1;
            end else begin
                cur_s = s;
                for (int b = 0; b < h; b++) begin
                    if (acc_w[i]) begin
                        if (s + b < NC) e_oe[s + b] = 1;
                        if (s + b - 1 < NC) e_req[s + b - 1] = 1;
                    end else if (s + b + 1 < NC) begin
                        e_rdv[s + b + 1]   = 1;
                        e_rdsrc[s + b + 1] = s + b;
                    end
                end
                if (s + h < NC) e_done[s + h] = 1;
            end
        end
        if (rst_cyc >= 0) begin
            e_req[rst_cyc] = 0;
            for (int c = rst_cyc + 1; c < NC; c++) begin
                e_rdv[c] = 0; e_done[c] = 0; e_req[c] = 0; e_oe[c] = 0;
                e_full[c] = 0; e_ovf[c] = 0; e_coll[c] = 0;
            end
        end
    endtask

    task automatic run_scenario(input int cl, input int cwl, input int al, input int bl, input int n);
        reset = 1'b1; cas_rdy = 1'b0; cas_req = 3'd0;
        CL = 5'(cl); CWL = 5'(cwl); AL = 5'(al); BL = 5'(bl);
        build_model(al + cl, al + cwl, bl / 2);
        repeat (2) @(posedge CK_t);
        #1;
        obs_done = 0; obs_first_rdv = -1; obs_first_oe = -1; obs_first_full = -1;
        obs_rdv_cnt = 0; obs_oe_cnt = 0; obs_coll = 0; obs_ovf = 0;
        for (int c = 0; c < n; c++) begin
            cas_rdy = ev_vld[c];
            cas_req = ev_req[c];
            dq_in   = W'($urandom);
            wr_data = W'($urandom);
            dq_hist[c] = dq_in;
            wr_hist[c] = wr_data;
            reset = (c == rst_cyc);
            @(negedge CK_t);
            chk("flags{rdv,done,req,oe,full,ovf,coll}", c,
                32'({rd_valid, rw_done, wr_data_req, dq_oe, q_full, err_ovf, err_coll}),
                32'({e_rdv[c], e_done[c], e_req[c], e_oe[c], e_full[c], e_ovf[c], e_coll[c]}));
            if (e_rdv[c]) chk("rd_data", c, 32'(rd_data), 32'(dq_hist[e_rdsrc[c]]));
            if (e_oe[c])  chk("dq_out", c, 32'(dq_out), 32'(wr_hist[c]));
            if (rw_done) obs_done++;
            if (rd_valid) begin
                obs_rdv_cnt++;
                if (obs_first_rdv < 0) obs_first_rdv = c;
            end
            if (dq_oe) begin
                obs_oe_cnt++;
                if (obs_first_oe < 0) obs_first_oe = c;
            end
            if (q_full && obs_first_full < 0) obs_first_full = c;
            obs_coll = err_coll;
            obs_ovf  = err_ovf;
            @(posedge CK_t);
            #1;
        end
        cas_rdy = 1'b0;
        reset   = 1'b0;
    endtask

    typedef struct {
        string      name;
        logic [2:0] req;
        int         cl, cwl, al, bl;
        int         exp_first;
        int         exp_done;
        int         exp_len;
    } vec_t;

    initial begin
        vec_t tbl[5];
        tbl[0] = '{"rd_bl8",  RD_R,  11, 9, 0, 8, 22, 25, 4};
        tbl[1] = '{"wr_bl8",  WR_R,  11, 9, 0, 8, 19, 23, 4};
        tbl[2] = '{"rd_bc4",  RD_R,  11, 9, 0, 4, 22, 23, 2};
        tbl[3] = '{"rda_al3", RDA_R, 11, 9, 3, 8, 25, 28, 4};
        tbl[4] = '{"wra_bc4", WRA_R, 11, 7, 2, 4, 19, 21, 2};

        // reset state of the outputs before any scenario
        @(negedge CK_t);
        chk("reset_outputs", 0, 32'({rd_valid, rw_done, wr_data_req, dq_oe, q_full, err_ovf, err_coll}), 32'd0);

        foreach (tbl[i]) begin
            bit is_wr;
            is_wr = (tbl[i].req == WR_R) || (tbl[i].req == WRA_R);
            clear_ev();
            ev_vld[10] = 1'b1;
            ev_req[10] = tbl[i].req;
            run_scenario(tbl[i].cl, tbl[i].cwl, tbl[i].al, tbl[i].bl, 40);
            chk({tbl[i].name, "_first"}, 0, is_wr ? obs_first_oe : obs_first_rdv, tbl[i].exp_first);
            chk({tbl[i].name, "_len"}, 0, is_wr ? obs_oe_cnt : obs_rdv_cnt, tbl[i].exp_len);
            chk({tbl[i].name, "_done_cnt"}, 0, obs_done, 1);
        end

        // seamless reads
        clear_ev();
        ev_vld[10] = 1'b1; ev_req[10] = RD_R;
        ev_vld[14] = 1'b1; ev_req[14] = RD_R;
        run_scenario(11, 9, 0, 8, 40);
        chk("seam_done_cnt", 0, obs_done, 2);
        chk("seam_rdv_cnt", 0, obs_rdv_cnt, 8);
        chk("seam_no_coll", 0, 32'(obs_coll), 0);

        // collision: second start lands inside the first burst
        clear_ev();
        ev_vld[10] = 1'b1; ev_req[10] = RD_R;
        ev_vld[12] = 1'b1; ev_req[12] = RD_R;
        run_scenario(11, 9, 0, 8, 40);
        chk("coll_flag", 0, 32'(obs_coll), 1);
        chk("coll_done_cnt", 0, obs_done, 1);

        // overflow: five commands while nothing has drained yet
        clear_ev();
        for (int k = 0; k < 5; k++) begin
            ev_vld[10 + 4 * k] = 1'b1;
            ev_req[10 + 4 * k] = RD_R;
        end
        run_scenario(31, 9, 31, 8, 100);
        chk("ovf_full_at", 0, obs_first_full, 23);
        chk("ovf_flag", 0, 32'(obs_ovf), 1);
        chk("ovf_done_cnt", 0, obs_done, 4);

        // illegal request is dropped and flagged
        clear_ev();
        ev_vld[10] = 1'b1; ev_req[10] = 3'd6;
        run_scenario(11, 9, 0, 8, 30);
        chk("illegal_flag", 0, 32'(obs_ovf), 1);
        chk("illegal_done_cnt", 0, obs_done, 0);

        // reset during write beat 2
        clear_ev();
        ev_vld[10] = 1'b1; ev_req[10] = WR_R;
        rst_cyc = 21;
        run_scenario(11, 9, 0, 8, 30);
        chk("rst_oe_cnt", 0, obs_oe_cnt, 3);
        chk("rst_done_cnt", 0, obs_done, 0);

        // timestamp wrap
        clear_ev();
        ev_vld[245] = 1'b1; ev_req[245] = RD_R;
        run_scenario(11, 9, 0, 8, 270);
        chk("wrap_first_rdv", 0, obs_first_rdv, 257);
        chk("wrap_done_cnt", 0, obs_done, 1);

        // randomized mix; equal read/write latency keeps starts in issue order
        begin
            int t;
            int unsigned r;
            clear_ev();
            t = 5;
            while (t < 380) begin
                r = $urandom_range(0, 15);
                ev_vld[t] = 1'b1;
                case (r % 5)
                    0:       ev_req[t] = RD_R;
                    1:       ev_req[t] = RDA_R;
                    2:       ev_req[t] = WR_R;
                    3:       ev_req[t] = WRA_R;
                    default: ev_req[t] = (r == 4) ? 3'd7 : RD_R;
                endcase
                t += int'($urandom_range(2, 10));
            end
            run_scenario(7, 7, 0, 8, 400);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
